// File: rtl/pll_cfg_ctrl.sv
// pll_cfg_ctrl: rPLL divider-select sequencer with reset, debounced lock wait, retry and fault handling.
module pll_cfg_ctrl #(
    parameter logic [5:0] INIT_IDSEL   = 6'd0,
    parameter logic [5:0] INIT_FBDSEL  = 6'd0,
    parameter logic [5:0] INIT_ODSEL   = 6'd0,
    parameter int         RST_CYCLES   = 16,
    parameter int         LOCK_TIMEOUT = 27000,
    parameter int         LOCK_STABLE  = 64,
    parameter int         MAX_RETRIES  = 3
) (
    input  logic       clkin,
    input  logic       rst_n,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [5:0] cfg_idsel,
    input  logic [5:0] cfg_fbdsel,
    input  logic [5:0] cfg_odsel,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic [5:0] idsel,
    output logic [5:0] fbdsel,
    output logic [5:0] odsel,
    output logic       locked,
    output logic       busy,
    output logic       fault,
    output logic [1:0] retry_cnt
);
    localparam int RW = $clog2(RST_CYCLES + 1);
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);
    localparam int SW = $clog2(LOCK_STABLE + 1);

    typedef enum logic [1:0] {RST_PLL, WAIT_LOCK, LOCKED, FAULT} state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] rst_cnt_q, rst_cnt_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [SW-1:0] stab_cnt_q, stab_cnt_d;
    logic [1:0]    retry_q, retry_d;
    logic [5:0]    idsel_q, idsel_d, fbdsel_q, fbdsel_d, odsel_q, odsel_d;
    logic          lock_meta_q, lock_s_q;
    logic          accept, rst_done, lock_hit, tmo_hit, waiting;

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RST_PLL;
            rst_cnt_q   <= '0;
            tmo_cnt_q   <= '0;
            stab_cnt_q  <= '0;
            retry_q     <= '0;
            idsel_q     <= INIT_IDSEL;
            fbdsel_q    <= INIT_FBDSEL;
            odsel_q     <= INIT_ODSEL;
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            stab_cnt_q  <= stab_cnt_d;
            retry_q     <= retry_d;
            idsel_q     <= idsel_d;
            fbdsel_q    <= fbdsel_d;
            odsel_q     <= odsel_d;
            lock_meta_q <= pll_lock;
            lock_s_q    <= lock_meta_q;
        end
    end

    always_comb begin
        accept   = cfg_valid && cfg_ready;
        rst_done = rst_cnt_q == RW'(RST_CYCLES - 1);
        lock_hit = lock_s_q && stab_cnt_q == SW'(LOCK_STABLE - 1);
        tmo_hit  = tmo_cnt_q == TW'(LOCK_TIMEOUT - 1);
        state_d  = state_q;
        retry_d  = retry_q;
        idsel_d  = idsel_q;
        fbdsel_d = fbdsel_q;
        odsel_d  = odsel_q;
        unique case (state_q)
            RST_PLL:   state_d = rst_done ? WAIT_LOCK : RST_PLL;
            WAIT_LOCK: begin
                // lock takes priority over a coincident timeout
                if (lock_hit) begin
                    state_d = LOCKED;
                    retry_d = '0;
                end else if (tmo_hit) begin
                    state_d = retry_q == 2'(MAX_RETRIES) ? FAULT : RST_PLL;
                    retry_d = retry_q == 2'(MAX_RETRIES) || retry_q == 2'd3 ? retry_q : retry_q + 2'd1;
                end
            end
            LOCKED: begin
                if (!lock_s_q) begin
                    state_d = RST_PLL;
                    retry_d = '0;
                end
            end
            default:   state_d = FAULT;
        endcase
        // a new config overrides loss of lock on the same edge
        if (accept) begin
            state_d  = RST_PLL;
            retry_d  = '0;
            idsel_d  = cfg_idsel;
            fbdsel_d = cfg_fbdsel;
            odsel_d  = cfg_odsel;
        end
        waiting    = state_q == WAIT_LOCK && state_d == WAIT_LOCK;
        rst_cnt_d  = state_q == RST_PLL && !rst_done ? rst_cnt_q + RW'(1) : '0;
        tmo_cnt_d  = waiting ? tmo_cnt_q + TW'(1) : '0;
        stab_cnt_d = waiting && lock_s_q ? stab_cnt_q + SW'(1) : '0;
    end

    always_comb begin
        pll_reset = state_q == RST_PLL || state_q == FAULT;
        cfg_ready = state_q == LOCKED || state_q == FAULT;
        locked    = state_q == LOCKED;
        fault     = state_q == FAULT;
        busy      = state_q == RST_PLL || state_q == WAIT_LOCK;
        retry_cnt = retry_q;
        idsel     = idsel_q;
        fbdsel    = fbdsel_q;
        odsel     = odsel_q;
    end
endmodule
